// File: rtl/ex_redirect_ctrl_pkg.sv
// rtl/ex_redirect_ctrl_pkg.sv - shared execute-stage types and constants
//
// Contents:
//   ex_redir_state_e      redirect FSM state encoding (2-bit)
//   FLUSH_CYCLES_DEFAULT  default post-acknowledge flush length
//   flush_cnt_t           flush countdown counter type (holds 1..15)
//   ctrl_op_e             control-op decode shared with the arithmetic unit
//   redirect_target()     target after the JALR bit-0 clear
package ex_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    FLUSH    = 2'd2
  } ex_redir_state_e;

  localparam int unsigned FLUSH_CYCLES_DEFAULT = 1;

  typedef logic [3:0] flush_cnt_t;

  typedef enum logic [1:0] {
    CTRL_NONE   = 2'd0,
    CTRL_JAL    = 2'd1,
    CTRL_JALR   = 2'd2,
    CTRL_BRANCH = 2'd3
  } ctrl_op_e;

  // JALR discards bit 0 of the computed address; every other op keeps it.
  function automatic logic [31:0] redirect_target(input logic [31:0] result,
                                                  input ctrl_op_e    op);
    logic [31:0] t;
    t = result;
    if (op == CTRL_JALR) t[0] = 1'b0;
    return t;
  endfunction

endpackage

// File: rtl/ex_redirect_ctrl.sv
// rtl/ex_redirect_ctrl.sv - execute-stage control-flow redirect controller
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   ex_valid, ex_mem_stall    EX instruction valid / downstream freeze
//   ex_is_jal/jalr/branch     control-op flags from decode
//   ex_br_cond                branch comparison result
//   branch_result             target from the execute adder
//   IDEX_NowPC                PC of the EX instruction
//   fetch_ready               fetch accepts the pending redirect
//   redirect_valid/pc         registered redirect request to fetch
//   flush_ifid/idex           kill younger pipeline contents
//   ex_stall_req              hold EX while a redirect is in flight
//   exc_valid/pc/tval         misaligned-target exception report
//   redirect_count            completed redirects (wraps)
module ex_redirect_ctrl
  import ex_redirect_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_stall,
  input  logic        ex_is_jal,
  input  logic        ex_is_jalr,
  input  logic        ex_is_branch,
  input  logic        ex_br_cond,
  input  logic [31:0] branch_result,
  input  logic [31:0] IDEX_NowPC,
  input  logic        fetch_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        ex_stall_req,
  output logic        exc_valid,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_tval,
  output logic [31:0] redirect_count
);

  ex_redir_state_e state_q, state_d;
  flush_cnt_t      cnt_q, cnt_d;

  ctrl_op_e    op;
  logic        taken;
  logic        event_take;
  logic [31:0] target;

  logic [31:0] redirect_pc_d;
  logic [31:0] redirect_count_d;
  logic        exc_valid_d;
  logic [31:0] exc_pc_d;
  logic [31:0] exc_tval_d;

  // Decode flags into a single op; decode guarantees at most one is set,
  // the priority only makes the encoding well defined.
  always_comb begin
    op = CTRL_NONE;
    if (ex_is_jal)         op = CTRL_JAL;
    else if (ex_is_jalr)   op = CTRL_JALR;
    else if (ex_is_branch) op = CTRL_BRANCH;
  end

  assign taken      = (op == CTRL_JAL) || (op == CTRL_JALR) ||
                      ((op == CTRL_BRANCH) && ex_br_cond);
  assign target     = redirect_target(branch_result, op);
  assign event_take = ex_valid && !ex_mem_stall && (state_q == IDLE) && taken;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_pc_d    = redirect_pc;
    redirect_count_d = redirect_count;
    exc_valid_d      = 1'b0;
    exc_pc_d         = exc_pc;
    exc_tval_d       = exc_tval;

    case (state_q)
      IDLE: begin
        if (event_take) begin
          if (target[0]) begin
            // Misaligned target: report it and stay put, nothing to fetch.
            exc_valid_d = 1'b1;
            exc_pc_d    = IDEX_NowPC;
            exc_tval_d  = target;
          end else begin
            redirect_pc_d = target;
            state_d       = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (fetch_ready) begin
          cnt_d            = flush_cnt_t'(FLUSH_CYCLES);
          redirect_count_d = redirect_count + 32'd1;
          state_d          = FLUSH;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - flush_cnt_t'(1);
        if (cnt_d == '0) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_ifid     <= 1'b0;
      flush_idex     <= 1'b0;
      ex_stall_req   <= 1'b0;
      exc_valid      <= 1'b0;
      exc_pc         <= '0;
      exc_tval       <= '0;
      redirect_count <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      redirect_valid <= (state_d == WAIT_ACK);
      redirect_pc    <= redirect_pc_d;
      flush_ifid     <= (state_d != IDLE);
      flush_idex     <= (state_d != IDLE);
      ex_stall_req   <= (state_d != IDLE);
      exc_valid      <= exc_valid_d;
      exc_pc         <= exc_pc_d;
      exc_tval       <= exc_tval_d;
      redirect_count <= redirect_count_d;
    end
  end

endmodule
